// File: rtl/dcm_sup_pkg.sv
// Shared state encoding and default sizing for the DCM lock supervisor.
package dcm_sup_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PULSE_RST = 2'd1,
    LOCKED    = 2'd2,
    FAULT     = 2'd3
  } chan_state_e;

  localparam int DEF_NUM_DCM       = 3;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_RESET_PULSE   = 10;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 8;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcm_lock_supervisor_if.sv
// DCM-facing and system-facing status signals of the lock supervisor.
interface dcm_lock_supervisor_if
  import dcm_sup_pkg::*;
#(
  parameter int NUM_DCM = DEF_NUM_DCM
);
  logic [NUM_DCM-1:0] dcm_locked;
  logic [NUM_DCM-1:0] dcm_reset;
  logic [NUM_DCM-1:0] dcm_fault;
  logic [NUM_DCM-1:0] lock_lost;
  logic               system_reset;
  logic               system_ready;

  // Supervisor side: watches LOCKED, drives DCM resets and system status.
  modport master (
    input  dcm_locked,
    output dcm_reset, dcm_fault, lock_lost, system_reset, system_ready
  );

  // DCM / downstream side.
  modport slave (
    output dcm_locked,
    input  dcm_reset, dcm_fault, lock_lost, system_reset, system_ready
  );
endinterface

// File: rtl/dcm_lock_channel.sv
// One supervised DCM: LOCKED synchronizer, lock/timeout/retry FSM and sticky flags.
module dcm_lock_channel
  import dcm_sup_pkg::*;
#(
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int RESET_PULSE  = DEF_RESET_PULSE,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic crystal_clk,
  input  logic reset,
  input  logic dcm_locked_i,
  output logic dcm_reset_o,
  output logic dcm_fault_o,
  output logic lock_lost_o,
  output logic locked_o
);

  localparam int TIMER_W = cnt_width(LOCK_TIMEOUT);
  localparam int PULSE_W = cnt_width(RESET_PULSE + 1);
  localparam int RETRY_W = cnt_width(MAX_RETRIES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(RESET_PULSE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  chan_state_e        state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               dcm_reset_q, dcm_reset_d;
  logic               fault_q, fault_d;
  logic               lost_q, lost_d;

  // Next-state logic: wait for lock, pulse RST on timeout, give up after too many retries.
  always_comb begin
    sync1_d   = dcm_locked_i;
    sync2_d   = sync1_q;
    state_d   = state_q;
    timer_d   = timer_q;
    pulse_d   = pulse_q;
    retries_d = retries_q;
    lost_d    = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (timer_q != TIMER_LAST) timer_d = timer_q + 1'b1;
        if (sync2_q) begin
          state_d   = LOCKED;
          timer_d   = '0;
          retries_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (retries_q < RETRY_LIMIT) begin
            state_d   = PULSE_RST;
            pulse_d   = '0;
            retries_d = retries_q + 1'b1;
          end else begin
            state_d = FAULT;
          end
        end
      end
      PULSE_RST: begin
        if (pulse_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!sync2_q) begin
          state_d   = WAIT_LOCK;
          timer_d   = '0;
          retries_d = '0;
          lost_d    = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    dcm_reset_d = (state_d == PULSE_RST);
    fault_d     = (state_d == FAULT);
  end

  // State and counter registers; reset aborts any pulse in flight.
  always_ff @(posedge crystal_clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      timer_q     <= '0;
      pulse_q     <= '0;
      retries_q   <= '0;
      dcm_reset_q <= 1'b0;
      fault_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      timer_q     <= timer_d;
      pulse_q     <= pulse_d;
      retries_q   <= retries_d;
      dcm_reset_q <= dcm_reset_d;
      fault_q     <= fault_d;
      lost_q      <= lost_d;
    end
  end

  assign dcm_reset_o = dcm_reset_q;
  assign dcm_fault_o = fault_q;
  assign lock_lost_o = lost_q;
  assign locked_o    = (state_q == LOCKED);

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Supervises NUM_DCM clock managers and releases system reset once all are locked and settled.
module dcm_lock_supervisor
  import dcm_sup_pkg::*;
#(
  parameter int NUM_DCM       = DEF_NUM_DCM,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int RESET_PULSE   = DEF_RESET_PULSE,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input logic crystal_clk,
  input logic reset,
  dcm_lock_supervisor_if.master bus
);

  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [NUM_DCM-1:0]  ch_locked;
  logic [NUM_DCM-1:0]  ch_reset;
  logic [NUM_DCM-1:0]  ch_fault;
  logic [NUM_DCM-1:0]  ch_lost;
  logic                all_locked;
  logic                any_fault;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                system_ready_q, system_ready_d;
  logic                system_reset_q, system_reset_d;

  for (genvar g = 0; g < NUM_DCM; g++) begin : g_chan
    dcm_lock_channel #(
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .RESET_PULSE (RESET_PULSE),
      .MAX_RETRIES (MAX_RETRIES)
    ) u_chan (
      .crystal_clk (crystal_clk),
      .reset       (reset),
      .dcm_locked_i(bus.dcm_locked[g]),
      .dcm_reset_o (ch_reset[g]),
      .dcm_fault_o (ch_fault[g]),
      .lock_lost_o (ch_lost[g]),
      .locked_o    (ch_locked[g])
    );
  end

  assign all_locked = &ch_locked;
  assign any_fault  = |ch_fault;

  // Settle sequencer: count while every channel is locked, ready once the count completes.
  always_comb begin
    settle_d       = '0;
    system_ready_d = 1'b0;
    if (all_locked) begin
      settle_d       = (settle_q == SETTLE_LAST) ? settle_q : settle_q + 1'b1;
      system_ready_d = !any_fault && (system_ready_q || settle_q == SETTLE_LAST);
    end
    system_reset_d = !system_ready_d;
  end

  // Sequencer registers; downstream logic is held in reset from power-up.
  always_ff @(posedge crystal_clk or posedge reset) begin
    if (reset) begin
      settle_q       <= '0;
      system_ready_q <= 1'b0;
      system_reset_q <= 1'b1;
    end else begin
      settle_q       <= settle_d;
      system_ready_q <= system_ready_d;
      system_reset_q <= system_reset_d;
    end
  end

  assign bus.dcm_reset    = ch_reset;
  assign bus.dcm_fault    = ch_fault;
  assign bus.lock_lost    = ch_lost;
  assign bus.system_ready = system_ready_q;
  assign bus.system_reset = system_reset_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Bench for dcm_lock_supervisor: directed scenarios plus randomized lock traffic against a behavioural model.
module tb_dcm_lock_supervisor;

  localparam int N  = 3;
  localparam int LT = 20;
  localparam int RP = 4;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam logic [10:0] RESET_VEC = 11'b000_000_000_0_1;

  logic crystal_clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dcm_lock_supervisor_if #(.NUM_DCM(N)) bus();

  dcm_lock_supervisor #(
    .NUM_DCM(N), .LOCK_TIMEOUT(LT), .RESET_PULSE(RP),
    .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .crystal_clk(crystal_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 crystal_clk = ~crystal_clk;

  // Behavioural model: per-DCM locked flag, cycles waited, pulse cycles left, failures so far.
  bit m_s1 [N];
  bit m_s2 [N];
  bit m_lock [N];
  bit m_fault [N];
  bit m_lost [N];
  int m_wait [N];
  int m_pulse [N];
  int m_fails [N];
  int m_streak;
  bit m_ready;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lock[i] = 0; m_fault[i] = 0; m_lost[i] = 0;
      m_wait[i] = 0; m_pulse[i] = 0; m_fails[i] = 0;
    end
    m_streak = 0;
    m_ready  = 0;
  endtask

  task automatic model_step();
    bit all_pre;
    bit fault_pre;
    bit ls;
    if (reset) begin
      model_clear();
    end else begin
      all_pre   = 1;
      fault_pre = 0;
      for (int i = 0; i < N; i++) begin
        if (!m_lock[i]) all_pre = 0;
        if (m_fault[i]) fault_pre = 1;
      end
      m_ready  = all_pre && !fault_pre && (m_ready || m_streak >= SC - 1);
      m_streak = all_pre ? m_streak + 1 : 0;
      for (int i = 0; i < N; i++) begin
        ls = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = bus.dcm_locked[i];
        if (m_fault[i]) begin
        end else if (m_pulse[i] > 0) begin
          m_pulse[i]--;
          if (m_pulse[i] == 0) m_wait[i] = 0;
        end else if (m_lock[i]) begin
          if (!ls) begin
            m_lock[i] = 0; m_lost[i] = 1; m_wait[i] = 0; m_fails[i] = 0;
          end
        end else if (ls) begin
          m_lock[i] = 1; m_fails[i] = 0;
        end else if (m_wait[i] == LT - 1) begin
          if (m_fails[i] < MR) begin
            m_fails[i]++;
            m_pulse[i] = RP;
          end else begin
            m_fault[i] = 1;
          end
        end else begin
          m_wait[i]++;
        end
      end
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [2:0] r, f, l;
    for (int i = 0; i < N; i++) begin
      r[i] = (m_pulse[i] > 0);
      f[i] = m_fault[i];
      l[i] = m_lost[i];
    end
    return {r, f, l, m_ready, !m_ready};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.dcm_reset, bus.dcm_fault, bus.lock_lost, bus.system_ready, bus.system_reset};
  endfunction

  task automatic tick();
    @(posedge crystal_clk);
    model_step();
    @(negedge crystal_clk);
  endtask

  task automatic do_reset(input logic [2:0] init);
    @(negedge crystal_clk);
    reset = 1'b1;
    model_clear();
    bus.dcm_locked = init;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.dcm_locked = '0;
    #1 reset = 1'b1;
    model_clear();
    #1;
    n_cmp++;
    if (dut_vec() !== RESET_VEC) begin
      n_bad++; $display("[TB] FAIL reset_async got=%b want=%b", dut_vec(), RESET_VEC);
    end
    tick();
    tick();
    n_cmp++;
    if (dut_vec() !== RESET_VEC) begin
      n_bad++; $display("[TB] FAIL reset_held got=%b want=%b", dut_vec(), RESET_VEC);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_start();
    int first_ready = -1;
    int rst_cycles = 0;
    do_reset(3'b000);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL clean_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.system_ready === 1'b1 && first_ready < 0) first_ready = cyc;
      if (bus.dcm_reset !== 3'b000) rst_cycles++;
      if (cyc == 5) bus.dcm_locked = 3'b111;
    end
    n_cmp++;
    if (first_ready !== 16) begin
      n_bad++; $display("[TB] FAIL clean_ready_edge got=%0d want=16", first_ready);
    end
    n_cmp++;
    if (rst_cycles !== 0) begin
      n_bad++; $display("[TB] FAIL clean_no_dcm_reset got=%0d want=0", rst_cycles);
    end
    n_cmp++;
    if (bus.system_reset !== 1'b0) begin
      n_bad++; $display("[TB] FAIL clean_sys_reset got=%b want=0", bus.system_reset);
    end
  endtask

  task automatic test_late_lock();
    int rise = -1;
    int fall = -1;
    int npulse = 0;
    int first_ready = -1;
    logic prev = 1'b0;
    do_reset(3'b101);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL late_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.dcm_reset[1] === 1'b1 && !prev) begin
        npulse++;
        if (rise < 0) rise = cyc;
      end
      if (bus.dcm_reset[1] === 1'b0 && prev && fall < 0) fall = cyc;
      prev = bus.dcm_reset[1];
      if (bus.system_ready === 1'b1 && first_ready < 0) first_ready = cyc;
      if (cyc == 30) bus.dcm_locked[1] = 1'b1;
    end
    n_cmp++;
    if (rise !== 20) begin
      n_bad++; $display("[TB] FAIL late_pulse_start got=%0d want=20", rise);
    end
    n_cmp++;
    if (fall - rise !== RP) begin
      n_bad++; $display("[TB] FAIL late_pulse_width got=%0d want=%0d", fall - rise, RP);
    end
    n_cmp++;
    if (npulse !== 1) begin
      n_bad++; $display("[TB] FAIL late_pulse_count got=%0d want=1", npulse);
    end
    n_cmp++;
    if (first_ready !== 30 + SC + 3) begin
      n_bad++; $display("[TB] FAIL late_ready_edge got=%0d want=%0d", first_ready, 30 + SC + 3);
    end
  endtask

  task automatic test_fault();
    int npulse = 0;
    int fault_edge = -1;
    bit ready_seen = 0;
    logic prev = 1'b0;
    do_reset(3'b011);
    for (int cyc = 1; cyc <= 90; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL fault_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.dcm_reset[2] === 1'b1 && !prev) npulse++;
      prev = bus.dcm_reset[2];
      if (bus.dcm_fault[2] === 1'b1 && fault_edge < 0) fault_edge = cyc;
      if (bus.system_ready !== 1'b0) ready_seen = 1;
    end
    n_cmp++;
    if (npulse !== MR) begin
      n_bad++; $display("[TB] FAIL fault_pulse_count got=%0d want=%0d", npulse, MR);
    end
    n_cmp++;
    if (fault_edge !== 68) begin
      n_bad++; $display("[TB] FAIL fault_edge got=%0d want=68", fault_edge);
    end
    n_cmp++;
    if ({bus.dcm_fault, bus.dcm_reset} !== 6'b100_000) begin
      n_bad++; $display("[TB] FAIL fault_final got=%b want=100000", {bus.dcm_fault, bus.dcm_reset});
    end
    n_cmp++;
    if (ready_seen !== 1'b0) begin
      n_bad++; $display("[TB] FAIL fault_ready got=%b want=0", ready_seen);
    end
  endtask

  task automatic test_lock_loss();
    int first_ready = -1;
    do_reset(3'b111);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL loss_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.system_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL loss_pre_ready got=%b want=1", bus.system_ready);
    end
    bus.dcm_locked[0] = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.system_reset !== 1'b0) begin
      n_bad++; $display("[TB] FAIL loss_edge3 got=%b want=0", bus.system_reset);
    end
    tick();
    n_cmp++;
    if ({bus.system_reset, bus.lock_lost} !== 4'b1_001) begin
      n_bad++; $display("[TB] FAIL loss_edge4 got=%b want=1001", {bus.system_reset, bus.lock_lost});
    end
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL loss_model2 cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
    end
    bus.dcm_locked[0] = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL relock_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.system_ready === 1'b1 && first_ready < 0) first_ready = cyc;
    end
    n_cmp++;
    if (first_ready !== SC + 3) begin
      n_bad++; $display("[TB] FAIL relock_ready_edge got=%0d want=%0d", first_ready, SC + 3);
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset(3'b101);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL midpulse_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.dcm_reset !== 3'b010) begin
      n_bad++; $display("[TB] FAIL midpulse_active got=%b want=010", bus.dcm_reset);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== RESET_VEC) begin
      n_bad++; $display("[TB] FAIL midpulse_reset got=%b want=%b", dut_vec(), RESET_VEC);
    end
    model_clear();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_settle_race();
    bit ready_seen = 0;
    do_reset(3'b000);
    for (int cyc = 1; cyc <= 28; cyc++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("[TB] FAIL race_model cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.system_ready !== 1'b0) ready_seen = 1;
      if (cyc == 2) bus.dcm_locked = 3'b111;
      if (cyc == 9) bus.dcm_locked[2] = 1'b0;
    end
    n_cmp++;
    if (ready_seen !== 1'b0) begin
      n_bad++; $display("[TB] FAIL race_ready got=%b want=0", ready_seen);
    end
    n_cmp++;
    if (bus.lock_lost !== 3'b100) begin
      n_bad++; $display("[TB] FAIL race_lock_lost got=%b want=100", bus.lock_lost);
    end
  endtask

  task automatic test_random();
    int rate;
    for (int r = 0; r < 4; r++) begin
      rate = int'($urandom_range(6, 40));
      do_reset(3'($urandom));
      for (int cyc = 1; cyc <= 250; cyc++) begin
        tick();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++; $display("[TB] FAIL random_model round=%0d cyc=%0d got=%b want=%b", r, cyc, dut_vec(), exp_vec());
        end
        for (int ch = 0; ch < N; ch++) begin
          if ($urandom_range(0, rate - 1) == 0) bus.dcm_locked[ch] = ~bus.dcm_locked[ch];
        end
      end
    end
  endtask

  initial begin
    bus.dcm_locked = '0;
    test_reset();
    test_clean_start();
    test_late_lock();
    test_fault();
    test_lock_loss();
    test_reset_mid_pulse();
    test_settle_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
